// File: rtl/sd_image_xfer_ctrl.sv
// Stores/retrieves one image per slot as consecutive SD sectors; each sector is paced on FIFO level.
// Build macro SD_XFER_PATTERN_EN: save data comes from an internal counter and the write-FIFO is bypassed.
module sd_image_xfer_ctrl #(
  parameter int          DATA_W        = 16,
  parameter int          SECTOR_WORDS  = 256,
  parameter int          SLOT_NUM      = 4,
  parameter int          SLOT_SECTORS  = 1200,
  parameter logic [31:0] BASE_SECTOR   = 32'd16384,
  parameter int          FIFO_LEN_W    = 11,
  parameter int          RD_FIFO_DEPTH = 2048,
  localparam int         SLOT_W        = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1
) (
  input  logic                  SD_clk_ref,
  input  logic                  sys_rst_n,
  input  logic                  sd_init_done,
  input  logic                  save_req,
  input  logic                  read_req,
  input  logic [SLOT_W-1:0]     slot_sel,
  output logic                  wr_start_en,
  output logic [31:0]           wr_sec_addr,
  input  logic                  wr_busy,
  input  logic                  wr_req,
  output logic [DATA_W-1:0]     sd_wr_data,
  output logic                  rd_start_en,
  output logic [31:0]           rd_sec_addr,
  input  logic                  rd_busy,
  input  logic                  rd_val_en,
  input  logic [DATA_W-1:0]     rd_val_data,
  input  logic [FIFO_LEN_W-1:0] wr_fifo_len,
  output logic                  wr_fifo_rd_en,
  input  logic [DATA_W-1:0]     wr_fifo_data,
  input  logic [FIFO_LEN_W-1:0] rd_fifo_len,
  output logic                  rd_fifo_wr_en,
  output logic [DATA_W-1:0]     rd_fifo_wdata,
  output logic                  busy,
  output logic                  save_done,
  output logic                  read_done,
  output logic                  req_err,
  output logic                  flow_err,
  output logic [15:0]           sec_cnt
);

  typedef enum logic [2:0] {IDLE, W_WAIT, W_START, W_BUSY, R_WAIT, R_START, R_BUSY} state_t;

  localparam logic [31:0] SEC_WORDS32 = 32'(SECTOR_WORDS);
  localparam logic [31:0] RD_THRESH   = 32'(RD_FIFO_DEPTH - SECTOR_WORDS);
  localparam logic [31:0] RD_FULL     = 32'(RD_FIFO_DEPTH);
  localparam logic [31:0] SLOT_NUM32  = 32'(SLOT_NUM);
  localparam logic [31:0] SLOT_SEC32  = 32'(SLOT_SECTORS);
  localparam logic [15:0] LAST_SEC    = 16'(SLOT_SECTORS - 1);

  state_t      state, state_nxt;
  logic [31:0] base_addr;
  logic [31:0] sec_addr;
  logic        busy_seen;
  logic [31:0] slot_ext;
  logic [31:0] wr_len32, rd_len32;
  logic        req_ok, start_save, start_read;
  logic        wr_lvl_ok, rd_lvl_ok;
  logic        wr_fall, rd_fall, last_sec;

  assign slot_ext   = 32'(slot_sel);
  assign wr_len32   = 32'(wr_fifo_len);
  assign rd_len32   = 32'(rd_fifo_len);
  assign req_ok     = sd_init_done && (slot_ext < SLOT_NUM32);
  assign start_save = (state == IDLE) && save_req && req_ok;
  assign start_read = (state == IDLE) && read_req && !save_req && req_ok;
  assign rd_lvl_ok  = rd_len32 <= RD_THRESH;
  // The core's busy may lag the start pulse, so a fall only counts once busy has been seen high.
  assign wr_fall    = busy_seen && !wr_busy;
  assign rd_fall    = busy_seen && !rd_busy;
  assign last_sec   = sec_cnt == LAST_SEC;
  assign wr_sec_addr = sec_addr;
  assign rd_sec_addr = sec_addr;

`ifdef SD_XFER_PATTERN_EN
  logic [DATA_W-1:0] pat_cnt;

  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n)      pat_cnt <= '0;
    else if (start_save) pat_cnt <= '0;
    else if (wr_req)     pat_cnt <= pat_cnt + 1'b1;
  end

  assign wr_lvl_ok     = 1'b1;
  assign sd_wr_data    = pat_cnt;
  assign wr_fifo_rd_en = 1'b0;
`else
  assign wr_lvl_ok     = wr_len32 >= SEC_WORDS32;
  assign sd_wr_data    = wr_fifo_data;
  assign wr_fifo_rd_en = wr_req;
`endif

  assign rd_fifo_wr_en = rd_val_en;
  assign rd_fifo_wdata = rd_val_data;

  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_save)      state_nxt = W_WAIT;
               else if (start_read) state_nxt = R_WAIT;
      W_WAIT:  if (wr_lvl_ok) state_nxt = W_START;
      W_START: state_nxt = W_BUSY;
      W_BUSY:  if (wr_fall) state_nxt = last_sec ? IDLE : W_WAIT;
      R_WAIT:  if (rd_lvl_ok) state_nxt = R_START;
      R_START: state_nxt = R_BUSY;
      R_BUSY:  if (rd_fall) state_nxt = last_sec ? IDLE : R_WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_start_en = 1'b0;
    rd_start_en = 1'b0;
    busy        = 1'b1;
    unique case (state)
      IDLE:    busy        = 1'b0;
      W_START: wr_start_en = 1'b1;
      R_START: rd_start_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      base_addr <= '0;
      sec_addr  <= '0;
      sec_cnt   <= '0;
      busy_seen <= 1'b0;
      save_done <= 1'b0;
      read_done <= 1'b0;
      req_err   <= 1'b0;
      flow_err  <= 1'b0;
    end else begin
      save_done <= (state == W_BUSY) && wr_fall && last_sec;
      read_done <= (state == R_BUSY) && rd_fall && last_sec;
      // In IDLE a simultaneous read loses to the save; outside IDLE every request is refused.
      if (state == IDLE)
        req_err <= (save_req && read_req) || ((save_req || read_req) && !req_ok);
      else
        req_err <= save_req || read_req;
      if ((wr_req && (wr_fifo_len == '0)) || (rd_val_en && (rd_len32 == RD_FULL)))
        flow_err <= 1'b1;
      if (start_save || start_read) begin
        base_addr <= BASE_SECTOR + slot_ext * SLOT_SEC32;
        sec_cnt   <= '0;
      end
      if ((state == W_WAIT && wr_lvl_ok) || (state == R_WAIT && rd_lvl_ok))
        sec_addr <= base_addr + 32'(sec_cnt);
      if ((state == W_BUSY && wr_fall && !last_sec) || (state == R_BUSY && rd_fall && !last_sec))
        sec_cnt <= sec_cnt + 16'd1;
      if (state == W_START || state == R_START)
        busy_seen <= 1'b0;
      else if ((state == W_BUSY && wr_busy) || (state == R_BUSY && rd_busy))
        busy_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_image_xfer_ctrl.sv
// Randomised bench for sd_image_xfer_ctrl: a core model answers each sector, a scoreboard checks starts, dones and errors.
module tb_sd_image_xfer_ctrl;
  localparam int          DATA_W        = 16;
  localparam int          SECTOR_WORDS  = 256;
  localparam int          SLOT_NUM      = 3;
  localparam int          SLOT_SECTORS  = 3;
  localparam int          FIFO_LEN_W    = 12;
  localparam int          RD_FIFO_DEPTH = 2048;
  localparam logic [31:0] BASE          = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          idx;
    bit          rd;
  } start_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sd_init_done = 1'b0;
  logic                  save_req = 1'b0;
  logic                  read_req = 1'b0;
  logic [1:0]            slot_sel = '0;
  logic                  wr_start_en, rd_start_en;
  logic [31:0]           wr_sec_addr, rd_sec_addr;
  logic                  wr_busy = 1'b0, wr_req = 1'b0, rd_busy = 1'b0, rd_val_en = 1'b0;
  logic [DATA_W-1:0]     sd_wr_data, rd_fifo_wdata;
  logic [DATA_W-1:0]     rd_val_data = '0, wr_fifo_data = '0;
  logic [FIFO_LEN_W-1:0] wr_fifo_len = 12'd300, rd_fifo_len = '0;
  logic                  wr_fifo_rd_en, rd_fifo_wr_en;
  logic                  busy, save_done, read_done, req_err, flow_err;
  logic [15:0]           sec_cnt;

  sd_image_xfer_ctrl #(
    .DATA_W(DATA_W), .SECTOR_WORDS(SECTOR_WORDS), .SLOT_NUM(SLOT_NUM),
    .SLOT_SECTORS(SLOT_SECTORS), .BASE_SECTOR(BASE), .FIFO_LEN_W(FIFO_LEN_W),
    .RD_FIFO_DEPTH(RD_FIFO_DEPTH)
  ) dut (
    .SD_clk_ref(clk), .sys_rst_n(rst_n), .sd_init_done(sd_init_done),
    .save_req(save_req), .read_req(read_req), .slot_sel(slot_sel),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_busy(wr_busy),
    .wr_req(wr_req), .sd_wr_data(sd_wr_data),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .rd_busy(rd_busy),
    .rd_val_en(rd_val_en), .rd_val_data(rd_val_data),
    .wr_fifo_len(wr_fifo_len), .wr_fifo_rd_en(wr_fifo_rd_en), .wr_fifo_data(wr_fifo_data),
    .rd_fifo_len(rd_fifo_len), .rd_fifo_wr_en(rd_fifo_wr_en), .rd_fifo_wdata(rd_fifo_wdata),
    .busy(busy), .save_done(save_done), .read_done(read_done), .req_err(req_err),
    .flow_err(flow_err), .sec_cnt(sec_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int cyc = 0, last_fall = 0, n_starts = 0;
  start_t exp_start[$];
  bit     exp_done[$];
  int     exp_err[$];
  start_t mon_e;
  bit     mon_d;
  int     mon_c;
  logic [DATA_W-1:0] pat_exp = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: each accepted transfer emits SLOT_SECTORS starts at base+k, then one done.
  task automatic push_xfer(input bit rd, input int slot);
    for (int k = 0; k < SLOT_SECTORS; k++) begin
      start_t e;
      e.addr = BASE + 32'(slot * SLOT_SECTORS + k);
      e.idx  = k;
      e.rd   = rd;
      exp_start.push_back(e);
    end
    exp_done.push_back(rd);
  endtask

  task automatic issue(input bit sv, input bit rd, input int slot, input bit in_xfer);
    bit ok;
    ok = sd_init_done && (slot < SLOT_NUM);
    @(posedge clk); #1;
    save_req = sv; read_req = rd; slot_sel = 2'(slot);
    if (in_xfer) begin
      if (sv || rd) exp_err.push_back(cyc + 1);
    end else begin
      if (sv && ok)             push_xfer(1'b0, slot);
      else if (rd && !sv && ok) push_xfer(1'b1, slot);
      if ((sv && rd) || ((sv || rd) && !ok)) exp_err.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    save_req = 1'b0; read_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(posedge clk); #2; n++; end
    repeat (3) @(posedge clk);
    #2;
    check("idle_timeout", busy, 0);
    check("pending_starts", exp_start.size(), 0);
    check("pending_dones", exp_done.size(), 0);
    check("pending_req_err", exp_err.size(), 0);
  endtask

  task automatic step(inout bit ab);
    if (!ab) begin
      @(posedge clk); #1;
      if (!rst_n) ab = 1'b1;
    end
  endtask

  // Core model: busy rises a little after each start, one word per cycle, busy falls afterwards.
  always begin : core_model
    bit ab;
    bit is_rd;
    @(negedge clk);
    ab = 1'b0;
    if (rst_n && (wr_start_en || rd_start_en)) begin
      is_rd = rd_start_en;
      repeat ($urandom_range(1, 3)) step(ab);
      if (!ab) begin
        if (is_rd) rd_busy = 1'b1; else wr_busy = 1'b1;
      end
      for (int i = 0; i < SECTOR_WORDS && !ab; i++) begin
        step(ab);
        if (!ab) begin
          if (is_rd) begin rd_val_en = 1'b1; rd_val_data = DATA_W'($urandom); end
          else begin wr_req = 1'b1; wr_fifo_data = DATA_W'($urandom); end
        end
      end
      step(ab);
      rd_val_en = 1'b0; wr_req = 1'b0;
      repeat ($urandom_range(1, 3)) step(ab);
      rd_busy = 1'b0; wr_busy = 1'b0;
      if (!ab) last_fall = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_start_en || rd_start_en) begin
        n_starts++;
        if (exp_start.size() == 0) check("unexpected_start", {wr_start_en, rd_start_en}, 0);
        else begin
          mon_e = exp_start.pop_front();
          check("start_dir", {wr_start_en, rd_start_en}, mon_e.rd ? 2'b01 : 2'b10);
          check("sec_addr", {wr_sec_addr, rd_sec_addr}, {mon_e.addr, mon_e.addr});
          check("sec_cnt", sec_cnt, mon_e.idx);
          if (mon_e.idx > 0) check("restart_gap", cyc - last_fall, 2);
        end
      end
      if (save_done || read_done) begin
        if (exp_done.size() == 0) check("unexpected_done", {save_done, read_done}, 0);
        else begin
          mon_d = exp_done.pop_front();
          check("done_kind", {save_done, read_done}, mon_d ? 2'b01 : 2'b10);
          check("done_latency", cyc - last_fall, 1);
        end
      end
      if (req_err) begin
        if (exp_err.size() == 0) check("unexpected_req_err", 1, 0);
        else begin
          mon_c = exp_err.pop_front();
          check("req_err_cycle", cyc, mon_c);
        end
      end
      if (wr_req) begin
`ifdef SD_XFER_PATTERN_EN
        check("pattern_data", {wr_fifo_rd_en, sd_wr_data}, {1'b0, pat_exp});
        pat_exp = pat_exp + 1'b1;
`else
        check("wr_passthru", {wr_fifo_rd_en, sd_wr_data}, {1'b1, wr_fifo_data});
`endif
      end
      if (rd_val_en) check("rd_passthru", {rd_fifo_wr_en, rd_fifo_wdata}, {1'b1, rd_val_data});
      if (save_req && !busy && sd_init_done && (slot_sel < 2'(SLOT_NUM))) pat_exp = '0;
    end
  end

  task automatic wait_busy_rise(input bit rd, input string name);
    int n = 0;
    while (!(rd ? rd_busy : wr_busy) && n < 60) begin @(posedge clk); #2; n++; end
    check(name, rd ? rd_busy : wr_busy, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_flow_err", flow_err, 0);
    check("rst_busy", busy, 0);
    check("rst_outputs", {save_done, read_done, wr_start_en, rd_start_en, req_err}, 0);
    check("rst_addr_cnt", {wr_sec_addr, sec_cnt}, 0);
    exp_start.delete(); exp_done.delete(); exp_err.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int start_mark;
    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("reset_busy", busy, 0);
    check("reset_starts", {wr_start_en, rd_start_en}, 0);
    check("reset_addrs", {wr_sec_addr, rd_sec_addr}, 0);
    check("reset_flags", {save_done, read_done, req_err, flow_err}, 0);
    check("reset_sec_cnt", sec_cnt, 0);
    #1 rst_n = 1'b1;

    // Rejections: core not initialised, then an out-of-range slot
    issue(1'b1, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2 check("reject_noinit_busy", busy, 0);
    sd_init_done = 1'b1;
    issue(1'b0, 1'b1, SLOT_NUM, 1'b0);
    repeat (3) @(posedge clk);
    #2 check("reject_slot_busy", busy, 0);
    check("reject_errs_seen", exp_err.size(), 0);

    // Save to slot 2 (address wraps past 2^32); level gating, then a read refused mid-save
`ifndef SD_XFER_PATTERN_EN
    wr_fifo_len = 12'd100;
`endif
    start_mark = n_starts;
    issue(1'b1, 1'b0, 2, 1'b0);
    repeat (20) @(posedge clk);
    #2 check("save_busy", busy, 1);
    check("save_gated_by_level", n_starts - start_mark, 0);
    wr_fifo_len = 12'd300;
    wait_busy_rise(1'b0, "save_core_busy");
    issue(1'b0, 1'b1, 1, 1'b1);
    wait_idle(4000);

    // Read from slot 0 held off while the read FIFO is above threshold
    rd_fifo_len = 12'd1900;
    start_mark = n_starts;
    issue(1'b0, 1'b1, 0, 1'b0);
    repeat (20) @(posedge clk);
    #2 check("read_gated_by_level", n_starts - start_mark, 0);
    rd_fifo_len = 12'd1792;
    wait_idle(4000);
    rd_fifo_len = '0;

    // Save and read together: the save wins
    issue(1'b1, 1'b1, 1, 1'b0);
    wait_idle(4000);

    // Randomised requests
    for (int r = 0; r < 5; r++) begin
      int op, slot;
      op   = $urandom_range(0, 2);
      slot = $urandom_range(0, 3);
      sd_init_done = ($urandom_range(0, 4) != 0);
      issue(op != 1, op != 0, slot, 1'b0);
      sd_init_done = 1'b1;
      wait_idle(4000);
    end

    // Underflow makes flow_err sticky; reset mid-W_BUSY clears it with no done pulse
    issue(1'b1, 1'b0, 0, 1'b0);
    wait_busy_rise(1'b0, "uf_core_busy");
    wr_fifo_len = '0;
    repeat (5) @(posedge clk);
    #2 check("underflow_flag", flow_err, 1);
    wr_fifo_len = 12'd300;
    repeat (20) @(posedge clk);
    #2 check("underflow_sticky", flow_err, 1);
    check("uf_in_transfer", busy, 1);
    do_reset();
    repeat (10) @(posedge clk);
    #2 check("post_reset_idle", {busy, flow_err}, 0);

    // Overflow while reading
    issue(1'b0, 1'b1, 1, 1'b0);
    wait_busy_rise(1'b1, "of_core_busy");
    rd_fifo_len = 12'd2048;
    repeat (5) @(posedge clk);
    #2 check("overflow_flag", flow_err, 1);
    rd_fifo_len = '0;
    do_reset();
    repeat (5) @(posedge clk);
    #2 check("final_idle", {busy, flow_err}, 0);
    check("final_pending", exp_start.size() + exp_done.size() + exp_err.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
